// File: rtl/sysbus_mem_responder.sv
// sysbus_mem_responder: system-bus memory responder.
// Accepts 8-beat line reads and writes addressed to the memory device ID,
// backed by a MEM_WORDS-deep word array. Reads return their beats LATENCY
// cycles after the request is acknowledged, with a valid/ack handshake
// per beat. Writes take one beat per two cycles and produce no response.

`ifndef SYSBUS_MEMORY
`define SYSBUS_MEMORY 4'h1
`endif

module sysbus_mem_responder #(
  parameter int BUS_DATA_WIDTH = 64,
  parameter int BUS_TAG_WIDTH  = 13,
  parameter int MEM_WORDS      = 4096,
  parameter int LATENCY        = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      bus_reqcyc,
  input  logic [BUS_DATA_WIDTH-1:0] bus_req,
  input  logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
  input  logic                      bus_respack,
  output logic                      bus_reqack,
  output logic                      bus_respcyc,
  output logic [BUS_DATA_WIDTH-1:0] bus_resp,
  output logic [BUS_TAG_WIDTH-1:0]  bus_resptag
);

  // Word index width and line index width (8 words per line).
  localparam int IDX_W  = $clog2(MEM_WORDS);
  localparam int LINE_W = IDX_W - 3;

  // Tag field positions.
  localparam int TAG_RD_BIT = 12;
  localparam int TAG_ID_HI  = 11;
  localparam int TAG_ID_LO  = 8;

  typedef enum logic [1:0] {
    IDLE,
    LAT,
    RESP,
    WDATA
  } state_t;

  state_t                    state;
  logic [BUS_DATA_WIDTH-1:0] mem [MEM_WORDS];
  logic [LINE_W-1:0]         line;
  logic [2:0]                beat;
  logic [3:0]                lat_cnt;

  logic                      req_hit;
  logic                      mem_we;
  logic [IDX_W-1:0]          wr_idx;
  logic [2:0]                rd_beat;
  logic [IDX_W-1:0]          rd_idx;
  logic                      unused_bits;

  // Request decode, write strobe and array addressing for the current cycle.
  always_comb begin
    req_hit     = bus_reqcyc && (bus_reqtag[TAG_ID_HI:TAG_ID_LO] == `SYSBUS_MEMORY);
    mem_we      = reset && (state == WDATA) && bus_reqcyc && !bus_reqack;
    wr_idx      = {line, beat};
    rd_beat     = (state == RESP) ? (beat + 3'd1) : 3'd0;
    rd_idx      = {line, rd_beat};
    unused_bits = ^{bus_req, bus_reqtag};
  end

  // Backing array: never reset, so contents survive a reset or aborted burst.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[wr_idx] <= bus_req;
    end
  end

  // Transaction FSM with registered bus outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      bus_reqack  <= 1'b0;
      bus_respcyc <= 1'b0;
      bus_resp    <= '0;
      bus_resptag <= '0;
      line        <= '0;
      beat        <= '0;
      lat_cnt     <= '0;
    end else begin
      bus_reqack <= 1'b0;
      case (state)
        IDLE: begin
          // The reqack cycle that closes a write burst is not a new request.
          if (req_hit && !bus_reqack) begin
            line        <= bus_req[IDX_W+2:6];
            bus_resptag <= bus_reqtag;
            beat        <= '0;
            bus_reqack  <= 1'b1;
            if (bus_reqtag[TAG_RD_BIT]) begin
              lat_cnt <= 4'(LATENCY - 1);
              state   <= LAT;
            end else begin
              state <= WDATA;
            end
          end
        end
        LAT: begin
          if (lat_cnt == 4'd0) begin
            bus_respcyc <= 1'b1;
            bus_resp    <= mem[rd_idx];
            state       <= RESP;
          end else begin
            lat_cnt <= lat_cnt - 4'd1;
          end
        end
        RESP: begin
          if (bus_respcyc && bus_respack) begin
            beat <= beat + 3'd1;
            if (beat == 3'd7) begin
              bus_respcyc <= 1'b0;
              bus_resp    <= '0;
              state       <= IDLE;
            end else begin
              bus_resp <= mem[rd_idx];
            end
          end
        end
        WDATA: begin
          if (bus_reqcyc && !bus_reqack) begin
            bus_reqack <= 1'b1;
            beat       <= beat + 3'd1;
            if (beat == 3'd7) begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/sysbus_mem_responder.md
SYSBUS_MEM_RESPONDER -- requirements
Module: sysbus_mem_responder

Interface
REQ-001 SHALL have parameter BUS_DATA_WIDTH, default 64: request/response data width.
REQ-002 SHALL have parameter BUS_TAG_WIDTH, default 13: tag width.
REQ-003 SHALL have parameter MEM_WORDS, default 4096: backing array depth in 64-bit words, power of 2.
REQ-004 SHALL have parameter LATENCY, default 4, legal range 1..15: cycles from the read reqack cycle to the first respcyc cycle.
REQ-005 SHALL have port clk, input, 1: clock, rising edge.
REQ-006 SHALL have port reset, input, 1: reset, synchronous, active-low.
REQ-007 SHALL have port bus_reqcyc, input, 1: requester holds a request or write beat valid.
REQ-008 SHALL have port bus_req, input, BUS_DATA_WIDTH: byte address in the request phase; data in write beats.
REQ-009 SHALL have port bus_reqtag, input, BUS_TAG_WIDTH: bit 12 is 1 for read and 0 for write; bits 11:8 are the device ID.
REQ-010 SHALL have port bus_respack, input, 1: requester accepts the current response beat.
REQ-011 SHALL have port bus_reqack, output, 1: request or write beat accepted.
REQ-012 SHALL have port bus_respcyc, output, 1: response beat valid.
REQ-013 SHALL have port bus_resp, output, BUS_DATA_WIDTH: read data beat.
REQ-014 SHALL have port bus_resptag, output, BUS_TAG_WIDTH: latched request tag.

Function
REQ-015 SHALL implement states IDLE, LAT, RESP and WDATA; all outputs SHALL be registered.
REQ-016 In IDLE, when bus_reqcyc=1 and bus_reqtag[11:8]=`SYSBUS_MEMORY, SHALL latch the address and tag and drive bus_reqack=1 for exactly the next cycle.
REQ-017 Requests with any other device ID SHALL be ignored: no reqack and no state change.
REQ-018 Line base SHALL be the word index (bus_req>>3) with its low 3 bits cleared, then taken modulo MEM_WORDS; upper address bits SHALL be ignored, so the address wraps.
REQ-019 Read request (tag[12]=1): IDLE->LAT; the first respcyc SHALL be asserted LATENCY cycles after the reqack cycle.
REQ-020 RESP SHALL return 8 beats; beat i SHALL carry mem[base+i] in ascending order, and bus_resptag SHALL equal the latched tag.
REQ-021 Handshake: bus_respcyc, bus_resp and bus_resptag SHALL hold stable until a rising edge samples respcyc=1 and respack=1; the next beat SHALL be presented in the following cycle with no bubble.
REQ-022 After the 8th acknowledged beat, respcyc SHALL drop the following cycle and the FSM SHALL enter IDLE.
REQ-023 respack while respcyc=0 SHALL be ignored.
REQ-024 bus_reqcyc SHALL be ignored in LAT and RESP.
REQ-025 Write request (tag[12]=1'b0): IDLE->WDATA.
REQ-026 In WDATA, on each edge with reqcyc=1 and reqack currently 0, SHALL write bus_req to mem[base+beat] and drive reqack=1 for the next cycle; this gives at most 1 beat per 2 cycles.
REQ-027 After the 8th write beat is accepted, the FSM SHALL return to IDLE; writes SHALL produce no response beats.
REQ-028 A new request SHALL NOT be accepted earlier than the cycle after the FSM re-enters IDLE.
REQ-029 The beat counter SHALL be 3 bits; only the final beat's wrap from 7 to 0 SHALL end a transaction.

Reset
REQ-030 With reset=0 at a rising edge, the FSM SHALL enter IDLE and bus_reqack, bus_respcyc, bus_resp, bus_resptag and the counters SHALL all be 0.
REQ-031 Reset mid-burst SHALL abort the burst with no further beats and no partial state.
REQ-032 Memory contents SHALL be retained across reset and SHALL NOT be cleared.
REQ-033 Beats already written before an abort SHALL remain in memory.

Verification
REQ-034 Write 8 beats 0x11..0x88 to address 0x1000, then read 0x1000 -> reqack 1 cycle after the request; first respcyc 4 cycles after reqack; beats 0x11..0x88 in order; resptag = read tag.
REQ-035 Read 0x1038 (unaligned) -> same 8 beats starting 0x11 (line-aligned).
REQ-036 Hold respack=0 for 5 cycles on beat 2 -> respcyc and resp hold 0x33 stable; beat 3 (0x44) appears the cycle after respack=1.
REQ-037 Request with device ID != `SYSBUS_MEMORY -> reqack stays 0 for 20 cycles; state stays IDLE.
REQ-038 Assert reset=0 during beat 4 of a read -> next cycle respcyc=0 and resp=0; a re-read of 0x1000 returns 0x11..0x88.
REQ-039 With MEM_WORDS=4096, address 0x8000+0x1000 -> aliases to 0x1000 and returns 0x11..0x88.
